// File: rtl/ni_packetizer_pkg.sv
// ni_packetizer_pkg: shared types and helpers for the network-interface packetizer.
// Flit-type encodings, `AXIS and `DATA_WIDTH normally come from the shared
// parameters.v include. The guarded defaults below take effect only when that
// include has not already defined them, so nothing is ever redefined.
// Optional feature macro used by the top: NI_PARITY_EN (header even parity).
`ifndef AXIS
`define AXIS 2
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef BODY
`define BODY 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b011
`endif

package ni_packetizer_pkg;

   localparam int FT_W = 3;
   localparam int DW   = `DATA_WIDTH;
   localparam int AW   = `AXIS;

   typedef enum logic [1:0] {
      IDLE,
      HEAD,
      BODY
   } state_e;

   typedef logic [DW-1:0] flit_t;

   // Payload flit: type in the top bits, payload word in the rest.
   function automatic flit_t mk_data_flit(input logic [FT_W-1:0] ft, input flit_t d);
      flit_t f;
      f = d;
      f[DW-1 -: FT_W] = ft;
      return f;
   endfunction

   // Even parity over everything above bit 0.
   function automatic logic even_par(input flit_t f);
      return ^f[DW-1:1];
   endfunction

endpackage

// File: rtl/ni_credit_cnt.sv
// ni_credit_cnt: saturating credit counter for the router local input FIFO.
// Range 0..CREDITS. A decrement and an increment in the same cycle cancel;
// an increment at full is dropped.
module ni_credit_cnt #(
   parameter  int CREDITS = 4,
   localparam int CW      = $clog2(CREDITS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          dec,
   input  logic          inc,
   output logic [CW-1:0] avail
);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: net change of one flit sent vs one credit returned.
   always_comb begin
      cnt_d = cnt_q;
      if (dec && !inc && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
      else if (inc && !dec && (cnt_q != CW'(CREDITS)))
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register; the FIFO is empty (all credits available) out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= CW'(CREDITS);
      else      cnt_q <= cnt_d;
   end

   assign avail = cnt_q;

endmodule

// File: rtl/ni_packetizer.sv
// ni_packetizer: turns a PE packet request plus payload words into
// HEADER / BODY... / TAIL flits towards the router local port, under
// credit-based flow control.
// Build option: define NI_PARITY_EN to put even parity in header bit 0.
module ni_packetizer
   import ni_packetizer_pkg::*;
#(
   parameter int CREDITS = 4,
   parameter int LEN_W   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [`AXIS-1:0]       cur_addr_rst,
   input  logic                   pe_req,
   input  logic [`AXIS-1:0]       pe_dst_addr,
   input  logic [LEN_W-1:0]       pe_len,
   output logic                   pe_ack,
   input  logic [`DATA_WIDTH-1:0] pe_data,
   input  logic                   pe_data_valid,
   output logic                   pe_data_ready,
   output logic [`DATA_WIDTH-1:0] flit_out,
   output logic                   flit_valid,
   input  logic                   credit_in,
   output logic                   busy
);

   localparam int CW = $clog2(CREDITS + 1);

   state_e           state_q;
   logic [AW-1:0]    cur_q, dst_q;
   logic [LEN_W-1:0] len_q, rem_q;
   flit_t            flit_q, hdr_d;
   logic             vld_q;
   logic [CW-1:0]    avail;
   logic             can_send;

   // The counter only sees a flit once flit_valid is up, so a flit launched
   // last cycle still holds a credit that the counter has not yet taken.
   assign can_send = avail > CW'(vld_q);

   ni_credit_cnt #(.CREDITS(CREDITS)) u_credit (
      .clk   (clk),
      .rst   (rst),
      .dec   (vld_q),
      .inc   (credit_in),
      .avail (avail)
   );

   // Acceptance is visible in the request cycle; held low while in reset.
   assign pe_ack        = rst & (state_q == IDLE) & pe_req & (pe_len != '0);
   assign pe_data_ready = (state_q == BODY) & can_send;
   assign busy          = (state_q != IDLE);
   assign flit_out      = flit_q;
   assign flit_valid    = vld_q;

   // Header assembly: type, dst, own address, length, zero fill, bit 0 option.
   always_comb begin
      hdr_d = '0;
      hdr_d[DW-1 -: FT_W]           = `HEADER;
      hdr_d[DW-1-FT_W -: AW]        = dst_q;
      hdr_d[DW-1-FT_W-AW -: AW]     = cur_q;
      hdr_d[DW-1-FT_W-2*AW -: LEN_W] = len_q;
`ifdef NI_PARITY_EN
      hdr_d[0] = even_par(hdr_d);
`else
      hdr_d[0] = 1'b0;
`endif
   end

   // Packet FSM with registered flit outputs; reset drops any partial packet.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cur_q   <= cur_addr_rst;
         dst_q   <= '0;
         len_q   <= '0;
         rem_q   <= '0;
         flit_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         vld_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pe_ack) begin
                  dst_q   <= pe_dst_addr;
                  len_q   <= pe_len;
                  state_q <= HEAD;
               end
            end
            HEAD: begin
               if (can_send) begin
                  flit_q  <= hdr_d;
                  vld_q   <= 1'b1;
                  rem_q   <= len_q;
                  state_q <= BODY;
               end
            end
            BODY: begin
               if (pe_data_valid && pe_data_ready) begin
                  flit_q <= mk_data_flit((rem_q == LEN_W'(1)) ? `TAIL : `BODY, pe_data);
                  vld_q  <= 1'b1;
                  rem_q  <= rem_q - 1'b1;
                  if (rem_q == LEN_W'(1)) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ni_packetizer.sv
// tb_ni_packetizer: directed and randomized checks of ni_packetizer against a
// packet-level reference (expected flit queue plus a credit budget).
module tb_ni_packetizer;

   localparam int C  = 4;
   localparam int LW = 4;
   localparam int DW = 32;
   localparam int AW = 2;
   localparam logic [2:0] T_H = 3'b001;
   localparam logic [2:0] T_B = 3'b010;
   localparam logic [2:0] T_T = 3'b011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [AW-1:0] cur, dst;
   logic          req, ack, dv, rdy, fv, ci, busy;
   logic [LW-1:0] len;
   logic [DW-1:0] data, fo;
   logic          b_req, b_ack, b_dv, b_rdy, b_fv, b_ci, b_busy;
   logic [LW-1:0] b_len;
   logic [DW-1:0] b_fo;

   ni_packetizer #(.CREDITS(C), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .cur_addr_rst(cur), .pe_req(req), .pe_dst_addr(dst),
      .pe_len(len), .pe_ack(ack), .pe_data(data), .pe_data_valid(dv),
      .pe_data_ready(rdy), .flit_out(fo), .flit_valid(fv), .credit_in(ci), .busy(busy)
   );

   ni_packetizer #(.CREDITS(2), .LEN_W(LW)) dut_b (
      .clk(clk), .rst(rst), .cur_addr_rst(cur), .pe_req(b_req), .pe_dst_addr(dst),
      .pe_len(b_len), .pe_ack(b_ack), .pe_data(data), .pe_data_valid(b_dv),
      .pe_data_ready(b_rdy), .flit_out(b_fo), .flit_valid(b_fv), .credit_in(b_ci), .busy(b_busy)
   );

   int            chks = 0;
   int            errs = 0;
   logic [31:0]   exp_q[$];
   logic [31:0]   fl_val[$];
   int            fl_cyc[$];
   int            mcred = C;
   int            cyc = 0;
   int            nfl = 0;
   int            b_nfl = 0;
   logic [AW-1:0] cur_lat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_hdr(input logic [1:0] d, input logic [1:0] c, input logic [3:0] l);
      logic [31:0] h;
      h = {T_H, d, c, l, 21'd0};
`ifdef NI_PARITY_EN
      h[0] = ^h[31:1];
`endif
      return h;
   endfunction

   // Scoreboard and credit budget, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         mcred = C;
      end else begin
         cyc++;
         if (fv) begin
            chk("credit_avail_at_send", 32'(mcred > 0), 1);
            chk("flit_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               chk("flit_value", fo, exp_q[0]);
               void'(exp_q.pop_front());
            end
            nfl++;
            fl_val.push_back(fo);
            fl_cyc.push_back(cyc);
         end
         mcred = mcred - int'(fv) + int'(ci);
         if (mcred > C) mcred = C;
         if (b_fv) b_nfl++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic run_pkt(input logic [1:0] d, input logic [3:0] l, input logic [31:0] base,
                          input int vprob, input int cprob, input bit poke);
      logic [31:0] words[$];
      logic [31:0] w;
      int idx, budget;
      bit poked;
      exp_q.push_back(exp_hdr(d, cur_lat, l));
      for (int i = 0; i < int'(l); i++) begin
         w = (base != 0) ? base + 32'(i) : $urandom;
         words.push_back(w);
         exp_q.push_back({(i == int'(l) - 1) ? T_T : T_B, w[28:0]});
      end
      @(posedge clk); #1;
      req = 1'b1; dst = d; len = l; #2;
      chk("pe_ack", 32'(ack), 1);
      @(posedge clk); #1;
      req = 1'b0;
      idx = 0; budget = 0; poked = 0;
      while ((idx < int'(l) || exp_q.size() > 0) && budget < 400) begin
         dv   = (idx < int'(l)) && ($urandom_range(0, 99) < vprob);
         data = (idx < int'(l)) ? words[idx] : $urandom;
         ci   = ($urandom_range(0, 99) < cprob);
         if (poke && !poked && idx == 1 && idx < int'(l)) begin
            req = 1'b1; len = 4'($urandom_range(1, 15)); poked = 1;
         end else begin
            req = 1'b0;
         end
         #2;
         if (req) chk("ack_while_busy", 32'(ack), 0);
         if (dv && rdy) idx++;
         @(posedge clk); #1;
         budget++;
      end
      dv = 1'b0; ci = 1'b0; req = 1'b0;
      chk("pkt_done", 32'(budget < 400), 1);
      if (budget >= 400) exp_q.delete();
      chk("credit_count", 32'(dut.u_credit.avail), 32'(mcred));
   endtask

   task automatic give_credits();
      repeat (C + 2) begin
         @(posedge clk); #1;
         ci = (mcred < C);
      end
      ci = 1'b0;
   endtask

   initial begin
      int n0, k;
      rst = 1'b0; cur = 2'b00; cur_lat = 2'b00; dst = '0; req = 1'b1; len = 4'd3;
      data = '0; dv = 1'b0; ci = 1'b0;
      b_req = 1'b0; b_len = '0; b_dv = 1'b0; b_ci = 1'b0;
      #12;
      // reset state, with a request held up to prove it is not acknowledged
      chk("rst_flit_valid", 32'(fv), 0);
      chk("rst_flit_out", fo, 0);
      chk("rst_pe_ack", 32'(ack), 0);
      chk("rst_ready", 32'(rdy), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_credits", 32'(dut.u_credit.avail), C);
      req = 1'b0;
      @(posedge clk); #3;
      rst = 1'b1;
      cur = 2'b01;

      // dst=3, len=3, data A,B,C on consecutive cycles, credits end at 0
      fl_val.delete(); fl_cyc.delete();
      run_pkt(2'b11, 4'd3, 32'hA, 100, 0, 0);
      chk("basic_nflits", 32'(fl_cyc.size()), 4);
      if (fl_cyc.size() == 4) begin
         chk("basic_consecutive", 32'(fl_cyc[3] - fl_cyc[0]), 3);
         chk("basic_hdr", fl_val[0], {T_H, 2'b11, 2'b00, 4'd3, 21'd0});
         chk("basic_tail", fl_val[3], {T_T, 29'hC});
`ifdef NI_PARITY_EN
         chk("hdr_parity", 32'(fl_val[0][0]), 32'(^fl_val[0][31:1]));
`else
         chk("hdr_bit0", 32'(fl_val[0][0]), 0);
`endif
      end
      chk("basic_credits_zero", 32'(dut.u_credit.avail), 0);

      // refill, then credit_in at full must saturate
      give_credits();
      @(posedge clk); #1; ci = 1'b1;
      repeat (3) @(posedge clk);
      #1; ci = 1'b0;
      @(posedge clk); #1;
      chk("credit_saturate", 32'(dut.u_credit.avail), C);

      // len=1: header then tail, idle the cycle after the tail
      fl_val.delete(); fl_cyc.delete();
      run_pkt(2'b10, 4'd1, 32'h0, 100, 0, 0);
      chk("len1_nflits", 32'(fl_cyc.size()), 2);
      if (fl_val.size() == 2) chk("len1_tail_type", 32'(fl_val[1][31:29]), 32'(T_T));
      chk("len1_busy_after", 32'(busy), 0);

      // len=0 request is ignored
      @(posedge clk); #1;
      req = 1'b1; len = 4'd0; dst = 2'b01; #2;
      chk("len0_ack", 32'(ack), 0);
      @(posedge clk); #1;
      req = 1'b0;
      n0 = nfl;
      repeat (4) @(posedge clk);
      #1;
      chk("len0_no_flit", 32'(nfl - n0), 0);
      chk("len0_busy", 32'(busy), 0);

      // request during BODY ignored; credits returned alongside flits
      give_credits();
      run_pkt(2'b01, 4'd5, 32'h0, 100, 50, 1);

      // randomized packets
      for (int p = 0; p < 12; p++)
         run_pkt(2'($urandom), 4'($urandom_range(1, 15)), 32'h0,
                 $urandom_range(40, 100), $urandom_range(20, 70), (p % 3) == 0);

      // CREDITS=2 instance: stall after two flits, one credit releases one flit
      @(posedge clk); #1;
      b_req = 1'b1; b_len = 4'd4; b_dv = 1'b1; data = 32'h1234_5678; #2;
      chk("b_ack", 32'(b_ack), 1);
      @(posedge clk); #1;
      b_req = 1'b0;
      n0 = b_nfl;
      repeat (8) @(posedge clk);
      #1;
      chk("b_stall_nflits", 32'(b_nfl - n0), 2);
      chk("b_stall_ready", 32'(b_rdy), 0);
      chk("b_stall_busy", 32'(b_busy), 1);
      b_ci = 1'b1;
      @(posedge clk); #1;
      b_ci = 1'b0; #1;
      chk("b_ready_after_credit", 32'(b_rdy), 1);
      repeat (6) @(posedge clk);
      #1;
      chk("b_one_more_flit", 32'(b_nfl - n0), 3);
      chk("b_stall_again", 32'(b_rdy), 0);
      b_dv = 1'b0;

      // asynchronous reset in the middle of BODY
      give_credits();
      exp_q.push_back(exp_hdr(2'b01, cur_lat, 4'd8));
      for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7) ? T_T : T_B, 29'h0ABC_DEF});
      n0 = nfl;
      @(posedge clk); #1;
      req = 1'b1; dst = 2'b01; len = 4'd8; data = 32'hE0AB_CDEF; dv = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      k = 0;
      while (nfl - n0 < 2 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk("midbody_reached", 32'(k < 20), 1);
      #1; rst = 1'b0; #1;
      chk("arst_flit_valid", 32'(fv), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_ready", 32'(rdy), 0);
      chk("arst_credits", 32'(dut.u_credit.avail), C);
      chk("arst_flit_out", fo, 0);
      chk("arst_b_busy", 32'(b_busy), 0);
      exp_q.delete();
      dv = 1'b0;
      cur = 2'b10; cur_lat = 2'b10;
      repeat (2) @(posedge clk);
      #3; rst = 1'b1;
      cur = 2'b01;

      // clean packet after reset, header carries the address latched in reset
      fl_val.delete(); fl_cyc.delete();
      run_pkt(2'b00, 4'd2, 32'h0, 100, 30, 0);
      if (fl_val.size() > 0) chk("post_rst_cur_addr", 32'(fl_val[0][26:25]), 32'(2'b10));
      chk("post_rst_nflits", 32'(fl_val.size()), 3);

      $display("Simulation finished: %0d checks, %0d errors", chks, errs);
      $finish;
   end

endmodule
